// File: rtl/pipe_pkg.sv
// pipe_pkg: write-back source and load-size encodings shared by the MEM/WB stage.
package pipe_pkg;
   localparam logic [1:0] WB_SEL_ALU = 2'b00;
   localparam logic [1:0] WB_SEL_MEM = 2'b01;
   localparam logic [1:0] WB_SEL_PC4 = 2'b10;
   localparam logic [1:0] WB_SEL_IMM = 2'b11;
   localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
   localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
   localparam logic [1:0] MEM_SIZE_WORD = 2'b10;
endpackage

// File: rtl/load_extract.sv
// load_extract: picks the addressed byte/half lane of a memory word and sign- or zero-extends it.
module load_extract
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OW     = $clog2(DATA_W/8)
) (
   input  logic [DATA_W-1:0] mem_data,
   input  logic [1:0]        mem_size,
   input  logic              mem_unsigned,
   input  logic [OW-1:0]     byte_off,
   output logic [DATA_W-1:0] data,
   output logic              misalign
);
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic        sx;
   assign lane_b = mem_data[{byte_off, 3'b000} +: 8];
   assign lane_h = mem_data[{byte_off[OW-1:1], 4'b0000} +: 16];
   assign sx = ~mem_unsigned;
   always_comb begin
      data = mem_size == MEM_SIZE_BYTE ? {{(DATA_W-8){sx & lane_b[7]}}, lane_b} :
             mem_size == MEM_SIZE_HALF ? {{(DATA_W-16){sx & lane_h[15]}}, lane_h} :
             mem_data;
   end
   assign misalign = (mem_size == MEM_SIZE_HALF) & byte_off[0];
endmodule

// File: rtl/wb_stage_param.sv
// wb_stage_param: MEM/WB register, write-back source mux and register-file write gating.
// Define WB_RETIRE_CNT_EN to build the 32-bit retire counter; otherwise retire_count is 0.
module wb_stage_param
   import pipe_pkg::*;
#(
   parameter int DATA_W        = 32,
   parameter int REG_AW        = 5,
   parameter int ZERO_REG_HARD = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   input  logic                        stall,
   input  logic                        flush,
   input  logic [DATA_W-1:0]           alu_result,
   input  logic [DATA_W-1:0]           mem_data,
   input  logic [DATA_W-1:0]           pc_plus4,
   input  logic [DATA_W-1:0]           imm_val,
   input  logic [1:0]                  wb_sel,
   input  logic [1:0]                  mem_size,
   input  logic                        mem_unsigned,
   input  logic [$clog2(DATA_W/8)-1:0] byte_off,
   input  logic                        reg_write,
   input  logic [REG_AW-1:0]           rd,
   output logic [DATA_W-1:0]           write_data,
   output logic [REG_AW-1:0]           write_addr,
   output logic                        reg_write_enable,
   output logic                        wb_valid,
   output logic                        misalign,
   output logic                        fwd_valid,
   output logic [31:0]                 retire_count
);
   localparam int OW = $clog2(DATA_W/8);
   logic              valid_q, reg_write_q, mem_unsigned_q;
   logic [REG_AW-1:0] rd_q;
   logic [1:0]        wb_sel_q, mem_size_q;
   logic [OW-1:0]     byte_off_q;
   logic [DATA_W-1:0] alu_q, mem_q, pc4_q, imm_q, load_data;
   logic              half_odd, zero_hit;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q        <= 1'b0;
         reg_write_q    <= 1'b0;
         rd_q           <= '0;
         wb_sel_q       <= '0;
         mem_size_q     <= '0;
         mem_unsigned_q <= 1'b0;
         byte_off_q     <= '0;
         alu_q          <= '0;
         mem_q          <= '0;
         pc4_q          <= '0;
         imm_q          <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (!stall) begin
         valid_q        <= in_valid;
         reg_write_q    <= reg_write;
         rd_q           <= rd;
         wb_sel_q       <= wb_sel;
         mem_size_q     <= mem_size;
         mem_unsigned_q <= mem_unsigned;
         byte_off_q     <= byte_off;
         alu_q          <= alu_result;
         mem_q          <= mem_data;
         pc4_q          <= pc_plus4;
         imm_q          <= imm_val;
      end
   end
   load_extract #(.DATA_W(DATA_W), .OW(OW)) u_load (
      .mem_data(mem_q),
      .mem_size(mem_size_q),
      .mem_unsigned(mem_unsigned_q),
      .byte_off(byte_off_q),
      .data(load_data),
      .misalign(half_odd)
   );
   always_comb begin
      write_data = wb_sel_q == WB_SEL_ALU ? alu_q :
                   wb_sel_q == WB_SEL_MEM ? load_data :
                   wb_sel_q == WB_SEL_PC4 ? pc4_q : imm_q;
   end
   assign misalign         = valid_q & (wb_sel_q == WB_SEL_MEM) & half_odd;
   assign zero_hit         = (ZERO_REG_HARD != 0) && (rd_q == '0);
   assign reg_write_enable = valid_q & reg_write_q & ~misalign & ~zero_hit;
   assign write_addr       = rd_q;
   assign wb_valid         = valid_q;
   assign fwd_valid        = reg_write_enable;
`ifdef WB_RETIRE_CNT_EN
   logic [31:0] retire_cnt;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) retire_cnt <= '0;
      else if (reg_write_enable && !stall) retire_cnt <= retire_cnt + 32'd1;
   end
   assign retire_count = retire_cnt;
`else
   assign retire_count = '0;
`endif
endmodule

// File: tb/tb_wb_stage_param.sv
// tb_wb_stage_param: directed checks of the MEM/WB stage with hand-computed expectations.
module tb_wb_stage_param;
   logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
   logic [31:0] alu_result = '0, mem_data = '0, pc_plus4 = '0, imm_val = '0;
   logic [1:0]  wb_sel = '0, mem_size = '0, byte_off = '0;
   logic        mem_unsigned = 1'b0, reg_write = 1'b0;
   logic [4:0]  rd = '0;
   logic [31:0] write_data, retire_count;
   logic [4:0]  write_addr;
   logic        reg_write_enable, wb_valid, misalign, fwd_valid;
   int errors = 0, checks = 0;

   wb_stage_param dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
      .alu_result(alu_result), .mem_data(mem_data), .pc_plus4(pc_plus4), .imm_val(imm_val),
      .wb_sel(wb_sel), .mem_size(mem_size), .mem_unsigned(mem_unsigned), .byte_off(byte_off),
      .reg_write(reg_write), .rd(rd), .write_data(write_data), .write_addr(write_addr),
      .reg_write_enable(reg_write_enable), .wb_valid(wb_valid), .misalign(misalign),
      .fwd_valid(fwd_valid), .retire_count(retire_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b1; reg_write = 1'b1;
      for (int i = 0; i < 3; i++) begin
         alu_result = $urandom; mem_data = $urandom; pc_plus4 = $urandom; imm_val = $urandom;
         wb_sel = 2'($urandom); mem_size = 2'($urandom); byte_off = 2'($urandom); rd = 5'($urandom | 1);
         step();
         checks++;
         if ({write_data, write_addr, reg_write_enable, wb_valid, misalign, fwd_valid, retire_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got wd=%h wa=%0d we=%b v=%b mis=%b fv=%b rc=%h required all 0",
                     write_data, write_addr, reg_write_enable, wb_valid, misalign, fwd_valid, retire_count);
         end
      end
      reset = 1'b0; wb_sel = 2'b00; alu_result = 32'h12345678; rd = 5'd5; mem_size = 2'b10;
      step();
      checks++;
      if ({write_data, write_addr, reg_write_enable} !== {32'h12345678, 5'd5, 1'b1}) begin
         errors++;
         $display("FAIL first_alu: got wd=%h wa=%0d we=%b required 12345678/5/1", write_data, write_addr, reg_write_enable);
      end
   endtask

   task automatic test_loads();
      logic [1:0]  sz [7] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b01};
      logic [1:0]  of [7] = '{2'd3, 2'd3, 2'd0, 2'd2, 2'd0, 2'd3, 2'd1};
      logic        us [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [31:0] ex [7] = '{32'hFFFFFF80, 32'h00000080, 32'h00000001, 32'hFFFF80FF,
                              32'h00007F01, 32'h80FF7F01, 32'h0};
      in_valid = 1'b1; reg_write = 1'b1; rd = 5'd7; wb_sel = 2'b01; mem_data = 32'h80FF7F01;
      for (int i = 0; i < 7; i++) begin
         mem_size = sz[i]; byte_off = of[i]; mem_unsigned = us[i];
         step();
         checks++;
         if (i < 6 && {write_data, misalign, reg_write_enable} !== {ex[i], 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL load_%0d: got wd=%h mis=%b we=%b required %h/0/1", i, write_data, misalign, reg_write_enable, ex[i]);
         end else if (i == 6 && {misalign, reg_write_enable, fwd_valid} !== 3'b100) begin
            errors++;
            $display("FAIL load_misalign: got mis=%b we=%b fv=%b required 1/0/0", misalign, reg_write_enable, fwd_valid);
         end
      end
      wb_sel = 2'b00;
      step();
      checks++;
      if (misalign !== 1'b0 || reg_write_enable !== 1'b1) begin
         errors++;
         $display("FAIL misalign_alu_only: got mis=%b we=%b required 0/1", misalign, reg_write_enable);
      end
   endtask

   task automatic test_sources();
      pc_plus4 = 32'h00001004; imm_val = 32'hABCDE000; alu_result = 32'h0BADF00D;
      wb_sel = 2'b10;
      step();
      checks++;
      if (write_data !== 32'h00001004) begin
         errors++;
         $display("FAIL src_pc4: got %h required 00001004", write_data);
      end
      wb_sel = 2'b11;
      step();
      checks++;
      if (write_data !== 32'hABCDE000) begin
         errors++;
         $display("FAIL src_imm: got %h required abcde000", write_data);
      end
   endtask

   task automatic test_zero_reg();
      rd = 5'd0; wb_sel = 2'b00;
      step();
      checks++;
      if ({reg_write_enable, fwd_valid, wb_valid} !== 3'b001) begin
         errors++;
         $display("FAIL zero_reg: got we=%b fv=%b v=%b required 0/0/1", reg_write_enable, fwd_valid, wb_valid);
      end
      rd = 5'd9; reg_write = 1'b0;
      step();
      checks++;
      if ({reg_write_enable, wb_valid} !== 2'b01) begin
         errors++;
         $display("FAIL no_reg_write: got we=%b v=%b required 0/1", reg_write_enable, wb_valid);
      end
      reg_write = 1'b1; in_valid = 1'b0;
      step();
      checks++;
      if ({reg_write_enable, wb_valid} !== 2'b00) begin
         errors++;
         $display("FAIL bubble: got we=%b v=%b required 0/0", reg_write_enable, wb_valid);
      end
   endtask

   task automatic test_stall_flush();
      in_valid = 1'b1; wb_sel = 2'b00; alu_result = 32'hAAAA0001; rd = 5'd3;
      step();
      alu_result = 32'hBBBB0002; rd = 5'd4; stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if ({write_data, write_addr, reg_write_enable} !== {32'hAAAA0001, 5'd3, 1'b1}) begin
            errors++;
            $display("FAIL stall_hold_%0d: got wd=%h wa=%0d we=%b required aaaa0001/3/1", i, write_data, write_addr, reg_write_enable);
         end
      end
      stall = 1'b0;
      step();
      checks++;
      if ({write_data, write_addr} !== {32'hBBBB0002, 5'd4}) begin
         errors++;
         $display("FAIL stall_release: got wd=%h wa=%0d required bbbb0002/4", write_data, write_addr);
      end
      flush = 1'b1; stall = 1'b1;
      step();
      checks++;
      if ({wb_valid, reg_write_enable} !== 2'b00) begin
         errors++;
         $display("FAIL flush_stall: got v=%b we=%b required 0/0", wb_valid, reg_write_enable);
      end
      flush = 1'b0; stall = 1'b0;
      step();
      checks++;
      if ({wb_valid, write_data} !== {1'b1, 32'hBBBB0002}) begin
         errors++;
         $display("FAIL after_flush: got v=%b wd=%h required 1/bbbb0002", wb_valid, write_data);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if ({wb_valid, reg_write_enable, write_data} !== '0) begin
         errors++;
         $display("FAIL async_reset: got v=%b we=%b wd=%h required 0/0/0", wb_valid, reg_write_enable, write_data);
      end
      step();
      reset = 1'b0;
   endtask

   task automatic test_counter();
      in_valid = 1'b1; reg_write = 1'b1; rd = 5'd6; wb_sel = 2'b00; stall = 1'b0;
      step();
      for (int i = 0; i < 10; i++) begin
         stall = (i < 3);
         step();
      end
      stall = 1'b0;
`ifdef WB_RETIRE_CNT_EN
      checks++;
      if (retire_count !== 32'd7) begin
         errors++;
         $display("FAIL retire_count: got %0d required 7", retire_count);
      end
      @(negedge clk);
      force dut.retire_cnt = 32'hFFFFFFFE;
      #1 release dut.retire_cnt;
      step();
      checks++;
      if (retire_count !== 32'hFFFFFFFF) begin
         errors++;
         $display("FAIL retire_max: got %h required ffffffff", retire_count);
      end
      step();
      checks++;
      if (retire_count !== 32'h0) begin
         errors++;
         $display("FAIL retire_wrap: got %h required 00000000", retire_count);
      end
`else
      checks++;
      if (retire_count !== 32'h0) begin
         errors++;
         $display("FAIL retire_tied: got %h required 00000000", retire_count);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_loads();
      test_sources();
      test_zero_reg();
      test_stall_flush();
      test_async_reset();
      test_counter();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/wb_stage_param.md
Name: wb_stage_param

Overview:
- Parametrised MEM/WB write-back stage: owns the MEM/WB pipeline register, selects write-back source, extracts and extends sub-word loads, and produces register-file write controls.
- Sits between the data-memory stage and the register file.
- Adds the following over the existing single-mux write-back:
  - stall/flush control
  - PC+4 and immediate sources for link and LUI
  - byte/half loads
  - zero-register write suppression
  - forwarding outputs for the hazard unit

Parameters:
- DATA_W, 32, datapath width in bits; multiple of 16, at least 32.
- REG_AW, 5, register address width.
- ZERO_REG_HARD, 1, when 1 a write to register 0 is suppressed.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  MEM stage holds a valid instruction.
- stall  in  1  hold the MEM/WB register.
- flush  in  1  invalidate the MEM/WB register.
- alu_result  in  DATA_W  ALU result from MEM stage.
- mem_data  in  DATA_W  raw data-memory read word.
- pc_plus4  in  DATA_W  link address.
- imm_val  in  DATA_W  pre-shifted immediate (LUI).
- wb_sel  in  2  source select: 00 ALU, 01 memory, 10 PC+4, 11 immediate.
- mem_size  in  2  load size: 00 byte, 01 half, 10/11 full word.
- mem_unsigned  in  1  zero-extend when 1, sign-extend when 0.
- byte_off  in  $clog2(DATA_W/8)  load byte offset (alu_result low bits).
- reg_write  in  1  instruction writes a register.
- rd  in  REG_AW  destination register.
- write_data  out  DATA_W  register-file write data.
- write_addr  out  REG_AW  register-file write address.
- reg_write_enable  out  1  register-file write strobe.
- wb_valid  out  1  stage holds a valid instruction.
- misalign  out  1  half-word load at an odd offset.
- fwd_valid  out  1  forwarding qualifier; equals reg_write_enable.
- retire_count  out  32  write-back count (see Optional Feature).

Behaviour:
- MEM/WB register contents: valid, reg_write, rd, wb_sel, mem_size, mem_unsigned, byte_off, alu_result, mem_data, pc_plus4, imm_val.
- Register update on each rising clk edge, in priority order:
  - reset: all register bits 0.
  - flush: valid <= 0; data fields don't-care, held.
  - stall: all fields held.
  - otherwise: all fields load from inputs; valid <= in_valid.
- flush and stall together: flush wins.
- Latency: 1 cycle from MEM inputs to write-back outputs. All outputs are combinational from registered fields only; no input-to-output combinational path.
- Load extraction:
  - byte: lane byte_off.
  - half: lane byte_off>>1.
  - full word: mem_data unchanged; byte_off ignored.
  - byte/half results are sign- or zero-extended to DATA_W per mem_unsigned.
- misalign = valid & (wb_sel==01) & (mem_size==01) & byte_off[0].
- write_data: mux of alu_result / extracted load / pc_plus4 / imm_val by registered wb_sel.
- write_addr = registered rd.
- reg_write_enable = valid & reg_write & ~misalign & ~(ZERO_REG_HARD & rd==0).
- wb_valid = valid. A stalled valid instruction keeps reg_write_enable asserted each cycle; rewriting the same value is harmless.
- Reset values: every output is 0, since all registered fields are 0.
- Reset asserted mid-operation clears valid immediately; no write strobe survives reset.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined: 32-bit counter increments on every clock edge where reg_write_enable=1 and stall=0.
  - Counter is reset to 0 by reset.
  - Wraps from 0xFFFFFFFF to 0.
  - Drives retire_count.
- Undefined: retire_count tied to 0; no counter flops are synthesised.

Decomposition:
- Shared package pipe_pkg holds:
  - WB_SEL_ALU/MEM/PC4/IMM encodings
  - MEM_SIZE_BYTE/HALF/WORD encodings
- Sub-module load_extract: purely combinational.
  - Inputs: mem_data, mem_size, mem_unsigned, byte_off.
  - Outputs: extended data and the misalign condition.
- The stage register and control gating stay in wb_stage_param.

Test Plan:
- Reset: hold reset with in_valid=1 and random inputs → all outputs 0. Release reset, then one edge with in_valid=1, wb_sel=00, alu_result=0x12345678, rd=5, reg_write=1 → write_data=0x12345678, write_addr=5, reg_write_enable=1.
- Byte load: mem_data=0x80FF7F01, mem_size=00, byte_off=3.
  - mem_unsigned=0 → 0xFFFFFF80.
  - mem_unsigned=1 → 0x00000080.
- Half load: mem_data=0x80FF7F01, mem_size=01.
  - byte_off=2, signed → 0xFFFF80FF.
  - byte_off=1 → misalign=1, reg_write_enable=0.
- Zero register: rd=0, reg_write=1, valid, ZERO_REG_HARD=1 → reg_write_enable=0, wb_valid=1.
- Stall/flush:
  - load valid instruction A, assert stall two cycles while presenting B → outputs stay A.
  - assert flush and stall together → wb_valid=0 next cycle.
- Counter (WB_RETIRE_CNT_EN): 10 enabled writes, 3 of them under stall → retire_count=7. Preload near 0xFFFFFFFF via a force → wraps to 0.
